// File: rtl/handshake_pkg.sv
// handshake_pkg
// Shared definitions for the elastic handshake fabric.
//   occ_e      : occupancy encoding of the 2-entry elastic buffer
//   RST_ACTIVE : level of the fabric reset that holds blocks in reset
package handshake_pkg;

    // Occupancy of a 2-entry elastic buffer. The encoding doubles as the
    // number of stored tokens.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // The fabric reset is active-low.
    localparam logic RST_ACTIVE = 1'b0;

endpackage : handshake_pkg

// File: rtl/handshake_fifo2.sv
// handshake_fifo2
// Generic 2-entry elastic buffer with a valid/ready handshake on both sides.
// ins_ready depends on registered occupancy only, so there is no
// combinational path from outs_ready to ins_ready.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   ins        in   [WIDTH] input token
//   ins_valid  in   input token present
//   ins_ready  out  buffer can accept a token
//   outs       out  [WIDTH] head token
//   outs_valid out  head token present
//   outs_ready in   downstream accepts the head token
module handshake_fifo2
    import handshake_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic [WIDTH-1:0] outs,
    output logic             outs_valid,
    input  logic             outs_ready
);

    occ_e             state;
    logic [WIDTH-1:0] head;   // oldest token, drives outs
    logic [WIDTH-1:0] tail;   // second token, only meaningful when FULL
    logic             push;
    logic             pop;

    // Ready is also forced low while reset is held so nothing is accepted
    // during the asynchronous reset window.
    assign ins_ready  = (state != OCC_FULL) & (rst != RST_ACTIVE);
    assign outs_valid = (state != OCC_EMPTY);
    assign outs       = head;

    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OCC_EMPTY;
            // NOTE: the storage entries are reset because head is visible
            // on outs, which must read 0 during reset.
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head  <= ins;
                        state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new token replaces it in place.
                        head <= ins;
                    end else if (push) begin
                        tail  <= ins;
                        state <= OCC_FULL;
                    end else if (pop) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // ins_ready is low here, so only a pop can occur.
                    if (pop) begin
                        head  <= tail;
                        state <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

endmodule : handshake_fifo2

// File: rtl/handshake_const_check.sv
// handshake_const_check
// Sink-side checker for a constant-producer channel. Each accepted token is
// compared against CONST_VALUE; the 1-bit result goes out through a 2-entry
// elastic buffer, and running match/mismatch counters are kept.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active-low
//   ins            in   [DATA_WIDTH] data token
//   ins_valid      in   token present
//   ins_ready      out  block can accept a token
//   outs           out  1 if the token equalled CONST_VALUE
//   outs_valid     out  result token present
//   outs_ready     in   downstream accepts the result
//   match_count    out  [CNT_WIDTH] accepted tokens that matched (wraps)
//   mismatch_count out  [CNT_WIDTH] accepted tokens that mismatched (wraps)
module handshake_const_check
    import handshake_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    // Typed at DATA_WIDTH so any override is zero-extended or truncated.
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic match_bit;
    logic push;

    assign match_bit = (ins == CONST_VALUE);
    assign push      = ins_valid & ins_ready;

    handshake_fifo2 #(
        .WIDTH (1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .ins        (match_bit),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    // Counters follow accepted tokens only, independent of downstream
    // back-pressure; both wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count    <= '0;
            mismatch_count <= '0;
        end else if (push) begin
            if (match_bit) match_count    <= match_count + CNT_ONE;
            else           mismatch_count <= mismatch_count + CNT_ONE;
        end
    end

endmodule : handshake_const_check

// File: tb/tb_handshake_const_check.sv
// tb_handshake_const_check
// Directed bench for handshake_const_check with CONST_VALUE = 0x2382 and
// 4-bit counters. Inputs change and outputs are sampled on the falling edge.
module tb_handshake_const_check;

    localparam int          DW = 32;
    localparam int          CW = 4;
    localparam logic [31:0] K  = 32'h0000_2382;

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          outs;
    logic          outs_valid;
    logic          outs_ready;
    logic [CW-1:0] match_count;
    logic [CW-1:0] mismatch_count;

    int n_checks = 0;
    int n_errors = 0;

    handshake_const_check #(
        .DATA_WIDTH  (DW),
        .CONST_VALUE (K),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ins            (ins),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .outs           (outs),
        .outs_valid     (outs_valid),
        .outs_ready     (outs_ready),
        .match_count    (match_count),
        .mismatch_count (mismatch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ins_valid = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    // Continuous push+pop stream; result of token i is seen after token i+1 is offered.
    logic [31:0] stream_tok [9] = '{K, 32'h0, K, K, 32'h7, K, 32'h0, 32'h8000_2382, K};
    logic        stream_exp [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst        = 1'b0;
        ins        = K;
        ins_valid  = 1'b1;
        outs_ready = 1'b1;

        // ---- reset then idle: token offered but nothing accepted ----
        cycle();
        cycle();
        check("rst_ins_ready",  32'(ins_ready), 0);
        check("rst_outs_valid", 32'(outs_valid), 0);
        check("rst_outs",       32'(outs), 0);
        check("rst_match",      32'(match_count), 0);
        check("rst_mismatch",   32'(mismatch_count), 0);
        ins_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("release_ins_ready", 32'(ins_ready), 1);
        @(negedge clk);

        // ---- streaming K, 0, K with outs_ready = 1 ----
        ins = K;       ins_valid = 1'b1;
        cycle();
        check("stream0_valid", 32'(outs_valid), 1);
        check("stream0_outs",  32'(outs), 1);
        ins = 32'h0;
        cycle();
        check("stream1_valid", 32'(outs_valid), 1);
        check("stream1_outs",  32'(outs), 0);
        ins = K;
        cycle();
        check("stream2_valid", 32'(outs_valid), 1);
        check("stream2_outs",  32'(outs), 1);
        check("stream_match",    32'(match_count), 2);
        check("stream_mismatch", 32'(mismatch_count), 1);
        ins_valid = 1'b0;
        cycle();
        check("stream_drained", 32'(outs_valid), 0);

        // ---- back-pressure: three tokens offered while stalled ----
        outs_ready = 1'b0;
        ins = K;           ins_valid = 1'b1;
        cycle();
        check("bp1_ins_ready", 32'(ins_ready), 1);
        check("bp1_outs",      32'(outs), 1);
        ins = 32'h5;
        cycle();
        check("bp2_ins_ready", 32'(ins_ready), 0);
        check("bp2_valid",     32'(outs_valid), 1);
        ins = K;
        cycle();
        check("bp3_ins_ready",  32'(ins_ready), 0);
        check("bp3_outs_held",  32'(outs), 1);
        check("bp3_match",      32'(match_count), 3);
        check("bp3_mismatch",   32'(mismatch_count), 2);
        outs_ready = 1'b1;
        cycle();
        check("bp_pop1_outs",      32'(outs), 0);
        check("bp_pop1_ins_ready", 32'(ins_ready), 1);
        check("bp_pop1_match",     32'(match_count), 3);
        cycle();
        check("bp_pop2_outs",     32'(outs), 1);
        check("bp_pop2_valid",    32'(outs_valid), 1);
        check("bp_third_match",   32'(match_count), 4);
        check("bp_third_mismatch", 32'(mismatch_count), 2);
        ins_valid = 1'b0;
        cycle();
        check("bp_drained", 32'(outs_valid), 0);

        // ---- simultaneous push+pop in ONE for 8 cycles ----
        ins = stream_tok[0]; ins_valid = 1'b1;
        cycle();
        for (int i = 1; i < 9; i++) begin
            check("pp_prev_outs", 32'(outs), 32'(stream_exp[i-1]));
            check("pp_valid",     32'(outs_valid), 1);
            check("pp_ins_ready", 32'(ins_ready), 1);
            ins = stream_tok[i];
            cycle();
        end
        check("pp_last_outs", 32'(outs), 32'(stream_exp[8]));
        ins_valid = 1'b0;
        cycle();
        check("pp_drained",  32'(outs_valid), 0);
        check("pp_match",    32'(match_count), 9);
        check("pp_mismatch", 32'(mismatch_count), 6);

        // ---- counter wrap with 4-bit counters: 17 matches ----
        do_reset();
        ins = K; ins_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cycle();
            if (k == 15) check("wrap_15", 32'(match_count), 15);
            if (k == 16) check("wrap_16", 32'(match_count), 0);
        end
        check("wrap_17",       32'(match_count), 1);
        check("wrap_mismatch", 32'(mismatch_count), 0);
        ins_valid = 1'b0;
        cycle();

        // ---- mid-operation reset while FULL ----
        outs_ready = 1'b0;
        ins = 32'h1; ins_valid = 1'b1;
        cycle();
        ins = 32'h2;
        cycle();
        check("full_ins_ready", 32'(ins_ready), 0);
        check("full_mismatch",  32'(mismatch_count), 2);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid",     32'(outs_valid), 0);
        check("midrst_ins_ready", 32'(ins_ready), 0);
        check("midrst_outs",      32'(outs), 0);
        check("midrst_match",     32'(match_count), 0);
        check("midrst_mismatch",  32'(mismatch_count), 0);
        @(negedge clk);
        rst = 1'b1;
        outs_ready = 1'b1;
        ins = K; ins_valid = 1'b1;
        cycle();
        check("post_rst_valid", 32'(outs_valid), 1);
        check("post_rst_outs",  32'(outs), 1);
        ins_valid = 1'b0;
        cycle();
        check("post_rst_drained",  32'(outs_valid), 0);
        check("post_rst_match",    32'(match_count), 1);
        check("post_rst_mismatch", 32'(mismatch_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_handshake_const_check

// File: doc/handshake_const_check.md
# handshake_const_check

Dataflow sink-side checker for the elastic handshake fabric. It is the consuming end of a constant-producer channel. It accepts data tokens, compares each against a compile-time constant, and emits a 1-bit match token on a decoupled output channel through a 2-entry buffer. It also keeps running match/mismatch counters for on-chip self-check of constant-generation paths.

## Interface
- `DATA_WIDTH`, 32, width of the incoming data token
- `CONST_VALUE`, 0, expected value; compared as `DATA_WIDTH` bits, zero-extended or truncated
- `CNT_WIDTH`, 16, width of each statistics counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset)
- `ins`  in  `DATA_WIDTH`  input data token
- `ins_valid`  in  1  input token present
- `ins_ready`  out  1  block can accept a token
- `outs`  out  1  match result: 1 if the token equaled `CONST_VALUE`
- `outs_valid`  out  1  result token present
- `outs_ready`  in  1  downstream accepts the result
- `match_count`  out  `CNT_WIDTH`  number of accepted tokens that matched
- `mismatch_count`  out  `CNT_WIDTH`  number of accepted tokens that mismatched

## Operation
- Push = `ins_valid & ins_ready`. Pop = `outs_valid & outs_ready`.
- On push, the compare bit `(ins == CONST_VALUE)` is written into a 2-entry FIFO. `ins` is not stored.
- Occupancy state machine:
  - EMPTY (0), ONE (1), FULL (2).
  - EMPTY + push → ONE.
  - ONE + push only → FULL.
  - ONE + pop only → EMPTY.
  - ONE + push + pop → ONE; the head becomes the new bit.
  - FULL + pop → ONE.
  - No other transitions.
- `ins_ready = (state != FULL) & rst`. It is a function of registered state only, with no combinational path from `outs_ready`.
- `outs_valid = (state != EMPTY)`. `outs` = head entry, stable while `outs_valid & !outs_ready`.
- Counters update on push only:
  - `match_count` += 1 when the bit is 1, else `mismatch_count` += 1.
  - Both wrap modulo 2^`CNT_WIDTH` (all-ones + 1 → 0).
  - Counting is independent of downstream back-pressure.
- Reset, asynchronous and immediate:
  - state = EMPTY, `outs_valid` = 0, `outs` = 0.
  - both counters = 0, `ins_ready` = 0 while `rst` = 0.
  - Tokens in flight are discarded; there is no partial pop.
- After `rst` deasserts, `ins_ready` = 1 and the first push can occur at the first rising edge.

## Timing
- Latency: a token pushed at edge N gives `outs_valid` = 1 after edge N, so the result is visible in the cycle after acceptance.
- Throughput: 1 token/cycle sustained while `outs_ready` = 1.
- Under a stalled downstream, the block absorbs 2 tokens, then `ins_ready` drops the cycle after the second push.
- On a stall release from FULL, `ins_ready` returns to 1 the cycle after the pop.
- Counters are registered and reflect a push one cycle after the accepting edge.

## Structure
- Shared package `handshake_pkg`:
  - occupancy encoding constants `OCC_EMPTY=2'd0`, `OCC_ONE=2'd1`, `OCC_FULL=2'd2`.
  - reset-polarity constant for the fabric.
- One sub-module is natural: `handshake_fifo2`, a generic 2-entry elastic buffer.
  - Parameterized by width; here instantiated at width 1.
  - Contains the occupancy state machine and ready/valid logic.
- The top holds the comparator and the two counters.

## Test plan
- Reset then idle: `rst`=0 with `ins_valid`=1 → `ins_ready`=0, `outs_valid`=0, counters 0. After release, `ins_ready`=1.
- Streaming, `CONST_VALUE`=27'h2382 (zero-extended), `outs_ready`=1:
  - Send 0x2382, 0x0, 0x2382 on consecutive cycles.
  - Expect `outs` = 1, 0, 1 one cycle later each.
  - Expect `match_count`=2, `mismatch_count`=1.
- Back-pressure, `outs_ready`=0, 3 tokens offered:
  - 2 accepted; `ins_ready`=0 after the second.
  - Raise `outs_ready` → results drain in order, third token accepted the cycle after the first pop.
- Simultaneous push+pop in ONE: occupancy stays ONE for 8 consecutive cycles with continuous streaming; no bubbles and no drops.
- Counter wrap, `CNT_WIDTH`=4: 17 matching tokens → `match_count`=1, `mismatch_count`=0.
- Mid-operation reset with FULL: assert `rst`=0 → `outs_valid` and `ins_ready` drop immediately and counters clear. After release, the first result corresponds to the first post-reset token.
